mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data port has priority over instruction fetch,
// with a starvation limit for fetch, a BUSY timeout and a sticky error state.
module mem_arbiter #(
  parameter int unsigned TIMEOUT    = 32,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  localparam int unsigned SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_BUSY = 3'd1,
    I_BUSY = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t        state;
  logic [SW-1:0] starve;
  logic [TW-1:0] tcnt;
  logic          data_req;
  logic          fetch_turn;

  assign data_req   = d_rd | d_wr;
  // Fetch wins only once data has been granted STARVE_LIM times in a row over it.
  assign fetch_turn = if_req & (starve == SW'(STARVE_LIM));

  assign d_stall  = (state == ERR) | (data_req & ~d_done);
  assign if_stall = (state == ERR) | (if_req & ~if_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      d_rdata   <= 16'h0000;
      if_rdata  <= 16'h0000;
      d_done    <= 1'b0;
      if_done   <= 1'b0;
      err       <= 1'b0;
      starve    <= '0;
      tcnt      <= '0;
    end else begin
      mem_en  <= 1'b0;
      d_done  <= 1'b0;
      if_done <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (d_rd && d_wr) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (data_req && !fetch_turn) begin
            state     <= D_BUSY;
            mem_en    <= 1'b1;
            mem_wr    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (if_req && (starve != SW'(STARVE_LIM)))
              starve <= starve + SW'(1);
          end else if (if_req) begin
            state     <= I_BUSY;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 16'h0000;
            starve    <= '0;
          end
        end
        D_BUSY, I_BUSY: begin
          if (mem_done) begin
            state <= DONE;
            if (state == I_BUSY) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end else begin
              if (!mem_wr)
                d_rdata <= mem_rdata;
              d_done <= 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DONE: state <= IDLE;
        ERR:  err   <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
